// File: rtl/fir_out_decim.sv
// Output stage of the 31-tap FIR: round, saturate, decimate and
// buffer samples in a first-word-fall-through FIFO for the consumer.
module fir_out_decim #(
    parameter int DECIM      = 4,
    parameter int SHIFT      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic signed [17:0]            y_in,
    input  logic                          done_in,
    input  logic                          phase_clr,
    output logic signed [7:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          sat_pulse
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic signed [18:0] HALF = 19'sd1 <<< (SHIFT - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic signed [18:0] t_sum;
    logic signed [18:0] q_val;
    logic               sat_hi;
    logic               sat_lo;
    logic signed [7:0]  rnd_val;

    logic [PW-1:0] phase;
    logic [PW-1:0] eff_phase;
    logic [PW-1:0] phase_nxt;
    logic          keep;

    logic              s1_valid;
    logic signed [7:0] s1_data;

    logic signed [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop;
    logic              push;
    logic              full;

    // Round half-up by biasing then flooring, clamp to signed 8 bits.
    always_comb begin
        t_sum   = {y_in[17], y_in} + HALF;
        q_val   = t_sum >>> SHIFT;
        sat_hi  = q_val > 19'sd127;
        sat_lo  = q_val < -19'sd128;
        rnd_val = 8'(q_val);
        if (sat_hi) rnd_val = 8'sd127;
        if (sat_lo) rnd_val = -8'sd128;
    end

    // Decimation decision; phase_clr forces this cycle's phase to zero.
    always_comb begin
        eff_phase = phase_clr ? '0 : phase;
        keep      = done_in && (eff_phase == '0);
        phase_nxt = eff_phase;
        if (done_in) begin
            phase_nxt = (eff_phase == PH_LAST) ? '0 : eff_phase + PW'(1);
        end
    end

    // Phase counter and the single register stage ahead of the FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase     <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            sat_pulse <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            s1_valid  <= keep;
            s1_data   <= rnd_val;
            sat_pulse <= done_in && (sat_hi || sat_lo);
        end
    end

    // FIFO handshake; a pop frees the slot so push-on-full-with-pop succeeds.
    always_comb begin
        out_valid = fifo_count != '0;
        full      = fifo_count == FULL_CNT;
        pop       = out_valid && out_ready;
        push      = s1_valid && (!full || pop);
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // FIFO storage; contents need no reset since count gates the output.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= s1_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) fifo_count <= fifo_count + (AW + 1)'(1);
            if (pop && !push) fifo_count <= fifo_count - (AW + 1)'(1);
            if (s1_valid && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: DECIM=4 and DECIM=1 instances share stimulus
// and are checked every cycle against a queue-based reference model.
module tb_fir_out_decim;

    logic               clock;
    logic               reset;
    logic signed [17:0] y_in;
    logic               done_in;
    logic               phase_clr;
    logic               out_ready;

    logic signed [7:0]  d0_data, d1_data;
    logic               d0_valid, d1_valid;
    logic [3:0]         d0_cnt, d1_cnt;
    logic               d0_ovf, d1_ovf;
    logic               d0_sat, d1_sat;

    int checks = 0;
    int failures = 0;

    fir_out_decim #(.DECIM(4), .SHIFT(10), .FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .y_in(y_in), .done_in(done_in),
        .phase_clr(phase_clr), .out_data(d0_data), .out_valid(d0_valid),
        .out_ready(out_ready), .fifo_count(d0_cnt), .overflow(d0_ovf),
        .sat_pulse(d0_sat)
    );

    fir_out_decim #(.DECIM(1), .SHIFT(10), .FIFO_DEPTH(8)) dut1 (
        .clock(clock), .reset(reset), .y_in(y_in), .done_in(done_in),
        .phase_clr(phase_clr), .out_data(d1_data), .out_valid(d1_valid),
        .out_ready(out_ready), .fifo_count(d1_cnt), .overflow(d1_ovf),
        .sat_pulse(d1_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model state, index 0 = DECIM 4, index 1 = DECIM 1
    int mq0[$];
    int mq1[$];
    int m_phase[2];
    bit m_pv[2];
    int m_pd[2];
    bit m_ovf[2];
    bit m_sat[2];

    function automatic int floor_q(int y);
        int t;
        t = y + 512;
        if (t >= 0) return t / 1024;
        return -((-t + 1023) / 1024);
    endfunction

    function automatic int mrnd(int y);
        int q;
        q = floor_q(y);
        if (q > 127) return 127;
        if (q < -128) return -128;
        return q;
    endfunction

    function automatic bit msat(int y);
        int q;
        q = floor_q(y);
        return (q > 127) || (q < -128);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int k, input int dec, input bit d,
                              input int y, input bit clr, input bit rdy,
                              input bit rst);
        int sz;
        bit keep;
        int eff;
        sz = (k == 0) ? mq0.size() : mq1.size();
        if (!rst) begin
            if (k == 0) mq0.delete(); else mq1.delete();
            m_phase[k] = 0;
            m_pv[k] = 0;
            m_pd[k] = 0;
            m_ovf[k] = 0;
            m_sat[k] = 0;
            return;
        end
        if (sz > 0 && rdy) begin
            if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
            sz--;
        end
        if (m_pv[k]) begin
            if (sz < 8) begin
                if (k == 0) mq0.push_back(m_pd[k]); else mq1.push_back(m_pd[k]);
            end else begin
                m_ovf[k] = 1;
            end
        end
        eff = clr ? 0 : m_phase[k];
        keep = d && (eff == 0);
        m_pv[k] = keep;
        m_pd[k] = mrnd(y);
        m_sat[k] = d && msat(y);
        if (d) m_phase[k] = (eff + 1) % dec;
        else if (clr) m_phase[k] = 0;
    endtask

    task automatic model_check();
        int e;
        chk("d4_valid", int'(d0_valid), int'(mq0.size() > 0));
        e = (mq0.size() > 0) ? mq0[0] : 0;
        chk("d4_data", int'(d0_data), e);
        chk("d4_count", int'(d0_cnt), mq0.size());
        chk("d4_overflow", int'(d0_ovf), int'(m_ovf[0]));
        chk("d4_sat", int'(d0_sat), int'(m_sat[0]));
        chk("d1_valid", int'(d1_valid), int'(mq1.size() > 0));
        e = (mq1.size() > 0) ? mq1[0] : 0;
        chk("d1_data", int'(d1_data), e);
        chk("d1_count", int'(d1_cnt), mq1.size());
        chk("d1_overflow", int'(d1_ovf), int'(m_ovf[1]));
        chk("d1_sat", int'(d1_sat), int'(m_sat[1]));
    endtask

    // one clock: drive inputs, take the edge, advance model, compare
    task automatic cyc(input bit d, input int y, input bit clr,
                       input bit rdy, input bit rst = 1'b1);
        done_in = d;
        y_in = 18'(y);
        phase_clr = clr;
        out_ready = rdy;
        reset = rst;
        @(posedge clock);
        model_edge(0, 4, d, y, clr, rdy, rst);
        model_edge(1, 1, d, y, clr, rdy, rst);
        #1;
        model_check();
    endtask

    typedef struct {
        int y;
        int exp_out;
        int exp_sat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b0;
        done_in = 1'b0;
        y_in = '0;
        phase_clr = 1'b0;
        out_ready = 1'b1;

        vecs.push_back('{511, 0, 0});
        vecs.push_back('{512, 1, 0});
        vecs.push_back('{-512, 0, 0});
        vecs.push_back('{-513, -1, 0});
        vecs.push_back('{-1536, -1, 0});
        vecs.push_back('{131071, 127, 1});
        vecs.push_back('{-131072, -128, 0});
        vecs.push_back('{1536, 2, 0});
        vecs.push_back('{130559, 127, 0});
        vecs.push_back('{130560, 127, 1});
        vecs.push_back('{-130561, -128, 0});

        // reset state
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("rst_valid", int'(d0_valid), 0);
        chk("rst_data", int'(d0_data), 0);
        chk("rst_count", int'(d0_cnt), 0);
        chk("rst_ovf", int'(d0_ovf), 0);
        chk("rst_sat", int'(d0_sat), 0);

        // DECIM=4: four pulses, only the first kept
        cyc(1, 1536, 0, 1);
        chk("dec4_lat_valid_early", int'(d0_valid), 0);
        cyc(1, 512, 0, 1);
        chk("dec4_lat_valid", int'(d0_valid), 1);
        chk("dec4_data", int'(d0_data), 2);
        cyc(1, -512, 0, 1);
        cyc(1, -1536, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("dec4_count_zero", int'(d0_cnt), 0);

        // DECIM=1 rounding and saturation table
        foreach (vecs[i]) begin
            cyc(1, vecs[i].y, 0, 1);
            chk("tab_sat", int'(d1_sat), vecs[i].exp_sat);
            cyc(0, 0, 0, 1);
            chk("tab_sat_clear", int'(d1_sat), 0);
            chk("tab_valid", int'(d1_valid), 1);
            chk("tab_data", int'(d1_data), vecs[i].exp_out);
        end
        cyc(0, 0, 0, 1);

        // overflow: 36 pulses, 9 kept, consumer stalled
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 36; i++) cyc(1, 1024 * (i / 4 + 1), 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("ovf_count", int'(d0_cnt), 8);
        chk("ovf_flag", int'(d0_ovf), 1);
        for (int n = 1; n <= 8; n++) begin
            chk("ovf_order", int'(d0_data), n);
            cyc(0, 0, 0, 1);
        end
        chk("ovf_drained", int'(d0_cnt), 0);
        chk("ovf_sticky", int'(d0_ovf), 1);

        // phase_clr with done_in at phase 2
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1024, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 2048, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 3072, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("clr_count", int'(d0_cnt), 3);
        for (int n = 1; n <= 3; n++) begin
            chk("clr_order", int'(d0_data), n);
            cyc(0, 0, 0, 1);
        end

        // full FIFO with simultaneous push and pop (DECIM=1)
        cyc(0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) cyc(1, 1024 * i, 0, 0);
        chk("full_count", int'(d1_cnt), 8);
        for (int i = 10; i <= 13; i++) cyc(1, 1024 * i, 0, 1);
        chk("full_pp_count", int'(d1_cnt), 8);
        chk("full_pp_ovf", int'(d1_ovf), 0);

        // reset with 5 buffered entries
        cyc(0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(1, 1024 * i, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pre_rst_count", int'(d1_cnt), 5);
        cyc(0, 0, 0, 0, 0);
        chk("mid_rst_count", int'(d1_cnt), 0);
        chk("mid_rst_valid", int'(d1_valid), 0);
        chk("mid_rst_data", int'(d1_data), 0);
        chk("mid_rst_ovf", int'(d1_ovf), 0);
        cyc(1, 4096, 0, 0);
        cyc(0, 0, 0, 0);
        chk("mid_rst_phase0", int'(d0_cnt), 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int yr;
            yr = int'($urandom_range(0, 262143)) - 131072;
            if ($urandom_range(0, 3) == 0) yr = int'($urandom_range(0, 4095)) - 2048;
            cyc(bit'($urandom_range(0, 3) != 0), yr,
                bit'($urandom_range(0, 15) == 0),
                bit'($urandom_range(0, 2) != 0),
                bit'($urandom_range(0, 299) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_out_decim.md
Name: fir_out_decim

Overview:
- Downstream stage of the 31-tap FIR. It consumes the 18-bit scaled filter output on each done pulse.
- Rounds and saturates the output to 8-bit signed, then decimates by DECIM.
- Buffers kept samples in a small first-word-fall-through FIFO with a valid/ready handshake toward the consumer (audio or display path).

Parameters:
- DECIM, 4: decimation factor; keep 1 of every DECIM input samples (1..16).
- SHIFT, 10: coefficient scale exponent; output = round(y_in / 2**SHIFT).
- FIFO_DEPTH, 8: FIFO entries; power of 2, range 2..32.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets the block on the next rising clock edge).
- y_in  input  18  signed FIR output; valid in the cycle done_in==1.
- done_in  input  1  single-cycle strobe that a new y_in is present.
- phase_clr  input  1  resynchronises the decimation phase to 0.
- out_data  output  8  signed head-of-FIFO sample; forced to 0 when out_valid==0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.
- sat_pulse  output  1  one-cycle pulse; the registered sample was saturated.

Behaviour:
- Reset (reset==0 at an edge) clears:
  - phase = 0, pipeline valid = 0, FIFO pointers and count = 0.
  - out_valid = 0, out_data = 0, overflow = 0, sat_pulse = 0.
  - Reset mid-operation discards all buffered and in-flight samples.
- Arithmetic, stage 1 (edge where done_in==1):
  - t = sign-extend(y_in, 19) + 2**(SHIFT-1).
  - q = t >>> SHIFT (arithmetic shift, floor), giving round-half-up toward +inf.
  - If q > 127, result = 127. If q < -128, result = -128. Either case sets sat_pulse for the cycle after.
- Decimation:
  - phase counts 0..DECIM-1 and advances mod DECIM on every done_in.
  - A sample is kept iff phase==0 when it arrives.
  - phase_clr forces phase to 0 for that cycle's decision. With simultaneous done_in, the sample is kept and phase becomes 1 (0 if DECIM==1). phase_clr alone sets phase = 0.
  - DECIM==1 keeps every sample.
  - Saturation and sat_pulse are evaluated for dropped samples too.
- Pipeline:
  - done_in sampled at edge k; rounded value and keep flag registered at edge k; FIFO write at edge k+1.
  - out_valid rises after edge k+1 if the FIFO was empty. Latency is 2 cycles from done_in to out_valid.
  - done_in may be asserted every cycle; full throughput, no stalls upstream.
- FIFO:
  - First-word fall-through; out_data = mem[rd_ptr] when count != 0.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged, allowed even when full (pop frees the slot first).
  - Push when full with no pop: sample dropped, overflow set, count stays FIFO_DEPTH. overflow clears only on reset.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ordering is strictly first in, first out.
- No other state machine beyond phase counter and FIFO control; no combinational path from y_in/done_in to outputs.

Test Plan:
- Reset, out_ready=1; four done_in pulses with y=1536, 512, -512, -1536 -> a single output, out_data=2, out_valid high 2 cycles after the first pulse; remaining three dropped; fifo_count returns to 0.
- DECIM=1; y = 511, 512, -512, -513, -1536 -> out_data 0, 1, 0, -1, -1 in order, sat_pulse never asserted.
- DECIM=1; y = 131071 -> out_data=127, sat_pulse=1 for one cycle; y = -131072 -> out_data=-128, sat_pulse=0.
- out_ready=0, 36 done_in pulses (9 kept, values 1..9 as y=1024*n) -> fifo_count=8, overflow=1; then out_ready=1 -> data 1..8 in order, overflow remains 1.
- phase_clr with done_in at phase 2 -> that sample is kept, next kept sample is 4 done_in later; FIFO full with simultaneous push and pop -> count stays 8, overflow stays 0.
- FIFO holding 5 entries, reset=0 for one edge -> next cycle fifo_count=0, out_valid=0, out_data=0, overflow=0, phase=0.
